// File: rtl/fft_bf_sched_pkg.sv
// Shared constants and types for the radix-2 DIT FFT butterfly sequencer.
// Latencies must agree with the data RAM, twiddle ROM and butterfly pipeline.
package fft_bf_sched_pkg;

  localparam int N_LOG2  = 8;
  localparam int RD_LAT  = 1;
  localparam int BF_LAT  = 3;
  localparam int DLY     = RD_LAT + BF_LAT;
  localparam int STAGE_W = $clog2(N_LOG2);
  localparam int J_W     = N_LOG2 - 1;
  localparam int CNT_W   = (DLY > 1) ? $clog2(DLY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // One slot of the write-back delay line
  typedef struct packed {
    logic              en;
    logic [N_LOG2-1:0] p;
    logic [N_LOG2-1:0] q;
  } wb_t;

endpackage

// File: rtl/fft_bf_sched_if.sv
// Control and memory-side bus of the butterfly sequencer.
// master = FFT top-level control view, slave = sequencer view.
interface fft_bf_sched_if;
  import fft_bf_sched_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic [STAGE_W-1:0] stage;
  logic               rd_en;
  logic [N_LOG2-1:0]  rd_addr_p;
  logic [N_LOG2-1:0]  rd_addr_q;
  logic [N_LOG2-2:0]  tw_addr;
  logic               bf_en;
  logic               wr_en;
  logic [N_LOG2-1:0]  wr_addr_p;
  logic [N_LOG2-1:0]  wr_addr_q;

  modport master (
    output start,
    input  busy, done, stage, rd_en, rd_addr_p, rd_addr_q, tw_addr,
           bf_en, wr_en, wr_addr_p, wr_addr_q
  );

  modport slave (
    input  start,
    output busy, done, stage, rd_en, rd_addr_p, rd_addr_q, tw_addr,
           bf_en, wr_en, wr_addr_p, wr_addr_q
  );

endinterface

// File: rtl/fft_bf_sched_addr_gen.sv
// Registered butterfly address generator: (stage s, butterfly j) -> p, q, twiddle index.
// Outputs update only when ld is high and hold otherwise.
module fft_bf_sched_addr_gen
  import fft_bf_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [STAGE_W-1:0] s,
  input  logic [J_W-1:0]     j,
  output logic [N_LOG2-1:0]  p,
  output logic [N_LOG2-1:0]  q,
  output logic [J_W-1:0]     tw
);

  logic [N_LOG2-1:0]  span;
  logic [N_LOG2-1:0]  pos;
  logic [N_LOG2-1:0]  grp;
  logic [N_LOG2-1:0]  p_c;
  logic [STAGE_W:0]   grp_sh;

  // grp_sh is one bit wider than s so that s+1 does not wrap in the last stage
  always_comb begin
    span   = N_LOG2'(1) << s;
    pos    = {1'b0, j} & (span - 1'b1);
    grp    = {1'b0, j} >> s;
    grp_sh = {1'b0, s} + 1'b1;
    p_c    = (grp << grp_sh) | pos;
  end

  // p has bit 'span' clear, so OR-ing it in is the same as p + span
  always_ff @(posedge clk) begin
    if (rst) begin
      p  <= '0;
      q  <= '0;
      tw <= '0;
    end else if (ld) begin
      p  <= p_c;
      q  <= p_c | span;
      tw <= J_W'(pos << (STAGE_W'(N_LOG2 - 1) - s));
    end
  end

endmodule

// File: rtl/fft_bf_sched.sv
// Butterfly sequencer for the in-place radix-2 DIT FFT: walks stages x N/2 butterflies,
// drives read/twiddle addresses and write-back addresses aligned to the butterfly output.
module fft_bf_sched
  import fft_bf_sched_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fft_bf_sched_if.slave  bus
);

  localparam logic [J_W-1:0]     J_LAST     = '1;
  localparam logic [STAGE_W-1:0] S_LAST     = STAGE_W'(N_LOG2 - 1);
  localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(DLY - 1);

  state_t             state;
  logic [STAGE_W-1:0] s;
  logic [J_W-1:0]     j;
  logic [CNT_W-1:0]   cnt;
  logic               rd_en_q;
  logic               busy_q;
  logic               done_q;

  logic               ld;
  logic [STAGE_W-1:0] ld_s;
  logic [J_W-1:0]     ld_j;
  logic [N_LOG2-1:0]  rd_p;
  logic [N_LOG2-1:0]  rd_q;
  logic [J_W-1:0]     tw;

  wb_t                dly [DLY];

  // Present to the address generator the butterfly that goes out next cycle
  always_comb begin
    ld   = 1'b0;
    ld_s = s;
    ld_j = j + 1'b1;
    case (state)
      S_IDLE: if (bus.start) begin
        ld   = 1'b1;
        ld_s = '0;
        ld_j = '0;
      end
      S_RUN: if (j != J_LAST) ld = 1'b1;
      S_DRAIN: if (cnt == DRAIN_LAST && s != S_LAST) begin
        ld   = 1'b1;
        ld_s = s + 1'b1;
        ld_j = '0;
      end
      default: ;
    endcase
  end

  fft_bf_sched_addr_gen u_addr_gen (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .s   (ld_s),
    .j   (ld_j),
    .p   (rd_p),
    .q   (rd_q),
    .tw  (tw)
  );

  // DRAIN idles the reads until the last write of the stage has landed (in-place RAW)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      s       <= '0;
      j       <= '0;
      cnt     <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          state   <= S_RUN;
          s       <= '0;
          j       <= '0;
          rd_en_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        S_RUN: begin
          if (j == J_LAST) begin
            state   <= S_DRAIN;
            cnt     <= '0;
            rd_en_q <= 1'b0;
          end else begin
            j <= j + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            j <= '0;
            if (s == S_LAST) begin
              state  <= S_DONE;
              s      <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state   <= S_RUN;
              s       <= s + 1'b1;
              rd_en_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {rd_en_q, rd_p, rd_q};
      for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = s;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_p = rd_p;
  assign bus.rd_addr_q = rd_q;
  assign bus.tw_addr   = tw;
  assign bus.bf_en     = dly[RD_LAT-1].en;
  assign bus.wr_en     = dly[DLY-1].en;
  assign bus.wr_addr_p = dly[DLY-1].p;
  assign bus.wr_addr_q = dly[DLY-1].q;

endmodule

// File: tb/tb_fft_bf_sched.sv
// Randomised scoreboard bench for fft_bf_sched: a schedule model pushes expected
// reads/writes per accepted start, a negedge monitor pops and compares.
module tb_fft_bf_sched;

  typedef struct {
    int cyc;
    int p;
    int q;
    int tw;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_bf_sched_if bus ();

  fft_bf_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  int   base      = -100000;
  int   idle_from = 0;
  int   wr_count  = 0;
  bit   armed     = 1'b0;
  bit   clean     = 1'b0;
  ev_t  rdq [$];
  ev_t  bfq [$];
  ev_t  wrq [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference schedule: stage s has N/(2*span) groups of span butterflies each
  task automatic pushRun(input int t);
    int   idx;
    int   span;
    ev_t  e;
    for (int s = 0; s < 8; s++) begin
      span = 1 << s;
      idx  = 0;
      for (int g = 0; g < 128 / span; g++) begin
        for (int pos = 0; pos < span; pos++) begin
          e.cyc = t + 1 + 132 * s + idx;
          e.p   = g * 2 * span + pos;
          e.q   = e.p + span;
          e.tw  = pos * (128 / span);
          rdq.push_back(e);
          e.cyc = e.cyc + 1;
          bfq.push_back(e);
          e.cyc = e.cyc + 3;
          wrq.push_back(e);
          idx++;
        end
      end
    end
  endtask

  // Drives one cycle of inputs; that cycle is "cycle 0" for a start accepted here
  task automatic applyStimulus(input logic st, input logic rs);
    @(negedge clk);
    #2;
    armed     = 1'b1;
    bus.start = st;
    rst       = rs;
    if (rs) begin
      idle_from = cyc + 1;
      rdq.delete();
      bfq.delete();
      wrq.delete();
      clean = 1'b1;
    end else if (st && cyc >= idle_from) begin
      base      = cyc;
      idle_from = cyc + 1058;
      wr_count  = 0;
      clean     = 1'b0;
      pushRun(cyc);
    end
  endtask

  task automatic runCycles(input int n, input int pct);
    for (int k = 1; k <= n; k++)
      applyStimulus((k < 1050) && ($urandom_range(0, 99) < pct), 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    ev_t  e;
    bit   exp_en;
    bit   live;
    int   rel;
    cyc++;
    if (armed) begin
      while (rdq.size() > 0 && rdq[0].cyc < cyc) e = rdq.pop_front();
      while (bfq.size() > 0 && bfq[0].cyc < cyc) e = bfq.pop_front();
      while (wrq.size() > 0 && wrq[0].cyc < cyc) e = wrq.pop_front();

      exp_en = rdq.size() > 0 && rdq[0].cyc == cyc;
      checkOutput("rd_en", bus.rd_en, exp_en);
      if (exp_en) begin
        e = rdq.pop_front();
        checkOutput("rd_addr_p", bus.rd_addr_p, e.p);
        checkOutput("rd_addr_q", bus.rd_addr_q, e.q);
        checkOutput("tw_addr", bus.tw_addr, e.tw);
      end

      exp_en = bfq.size() > 0 && bfq[0].cyc == cyc;
      checkOutput("bf_en", bus.bf_en, exp_en);
      if (exp_en) e = bfq.pop_front();

      exp_en = wrq.size() > 0 && wrq[0].cyc == cyc;
      checkOutput("wr_en", bus.wr_en, exp_en);
      if (exp_en) begin
        e = wrq.pop_front();
        checkOutput("wr_addr_p", bus.wr_addr_p, e.p);
        checkOutput("wr_addr_q", bus.wr_addr_q, e.q);
      end
      if (bus.wr_en === 1'b1) wr_count++;

      rel  = cyc - base;
      live = cyc < idle_from;
      checkOutput("busy", bus.busy, live && rel >= 1 && rel <= 1056);
      checkOutput("done", bus.done, live && rel == 1057);
      if (live && rel >= 1 && rel <= 1056) checkOutput("stage", bus.stage, (rel - 1) / 132);
      else if (!live) checkOutput("stage_idle", bus.stage, 0);

      if (live) begin
        case (rel)
          1: begin
            checkOutput("c1_p", bus.rd_addr_p, 0);
            checkOutput("c1_q", bus.rd_addr_q, 1);
            checkOutput("c1_tw", bus.tw_addr, 0);
          end
          2: begin
            checkOutput("c2_p", bus.rd_addr_p, 2);
            checkOutput("c2_q", bus.rd_addr_q, 3);
          end
          5: begin
            checkOutput("c5_wr_en", bus.wr_en, 1);
            checkOutput("c5_wr_p", bus.wr_addr_p, 0);
            checkOutput("c5_wr_q", bus.wr_addr_q, 1);
          end
          270: begin
            checkOutput("c270_p", bus.rd_addr_p, 9);
            checkOutput("c270_q", bus.rd_addr_q, 13);
            checkOutput("c270_tw", bus.tw_addr, 32);
          end
          1052: begin
            checkOutput("c1052_p", bus.rd_addr_p, 127);
            checkOutput("c1052_q", bus.rd_addr_q, 255);
            checkOutput("c1052_tw", bus.tw_addr, 127);
          end
          default: ;
        endcase
      end

      if (clean) begin
        checkOutput("rst_rd_p", bus.rd_addr_p, 0);
        checkOutput("rst_rd_q", bus.rd_addr_q, 0);
        checkOutput("rst_tw", bus.tw_addr, 0);
        checkOutput("rst_wr_p", bus.wr_addr_p, 0);
        checkOutput("rst_wr_q", bus.wr_addr_q, 0);
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0);

    $display("[TB] full run with starts at 50, 600 and in the DONE cycle");
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= 1065; k++)
      applyStimulus((k == 50) || (k == 600) || (k == 1057), 1'b0);
    checkOutput("wr_count_run1", wr_count, 1024);

    $display("[TB] random starts, 3-cycle reset mid-stream");
    repeat ($urandom_range(2, 8)) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    runCycles(699, 5);
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat ($urandom_range(3, 10)) applyStimulus(1'b0, 1'b0);

    $display("[TB] reset at 300, restart at 310");
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= 310; k++)
      applyStimulus(k == 310, k == 300);
    runCycles(1065, 4);
    checkOutput("wr_count_restart", wr_count, 1024);

    $display("[TB] start together with reset");
    applyStimulus(1'b1, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
